// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ / IDX_W : requester count and index width
//   arb_state_e     : arbiter state (idle / granted)
//   find_t, rr_find : rotating-priority search returning {found, index}
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } find_t;

    // First set bit of req scanning ptr, ptr+1, ... (mod NUM_REQ).
    // The loop runs from the far end so the nearest hit is written last.
    function automatic find_t rr_find(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        find_t            r;
        logic [IDX_W-1:0] i;
        r = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            i = ptr + IDX_W'(k);   // wraps naturally at NUM_REQ
            if (req[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec3.sv
// Combinational 3-to-8 decoder.
//   idx_i    : binary index
//   onehot_o : one-hot expansion of idx_i
module onehot_dec3
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    assign onehot_o = NUM_REQ'(1) << idx_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with registered one-hot grant.
// The owner keeps the grant until it drops its request; the release edge
// hands over directly to the next rotated winner.
// Optional hold limit: define ARB_TIMEOUT_EN to revoke a grant after
// MAX_HOLD cycles when another requester is waiting.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req       : request vector
//   gnt       : one-hot grant (registered), zero when idle
//   gnt_id    : binary owner index, valid while gnt_valid
//   gnt_valid : any grant active
//   timeout   : one-cycle pulse on a hold-limit revoke (0 without ARB_TIMEOUT_EN)
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..256");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [IDX_W-1:0]   id_q,    id_d;
    logic [NUM_REQ-1:0] dec_onehot;
    logic               owner_keeps;
    logic               preempt;
    logic               rearb;
    find_t              win;

    assign owner_keeps = (state_q == ARB_GRANT) && req[id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              to_q;

    assign preempt = owner_keeps && (hold_q == HOLD_LAST) && |(req & ~gnt_q);
    assign timeout = to_q;
`else
    assign preempt = 1'b0;
    assign timeout = 1'b0;
`endif

    assign rearb = !owner_keeps || preempt;

    // Owner bit masked so a revoked owner waits its turn; on a release it is
    // already zero, and in idle gnt_q is zero.
    assign win = rr_find(req & ~gnt_q, ptr_q);

    onehot_dec3 u_dec (
        .idx_i    (win.idx),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        if (rearb) begin
            if (win.found) begin
                state_d = ARB_GRANT;
                ptr_d   = win.idx + IDX_W'(1);
                gnt_d   = dec_onehot;
                id_d    = win.idx;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Restart on every arbitration, otherwise count up and saturate.
    always_comb begin
        hold_d = hold_q;
        if (rearb)                  hold_d = '0;
        else if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= preempt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

`ifdef ARB_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // reference model state: owner index (-1 none), pointer, hold cycles
    int m_own, m_ptr, m_hold;
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic [7:0] exp_gnt;
    } vec_t;

    vec_t vecs[12];

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_edge(input logic [7:0] r);
        logic [7:0] cand;
        bit         rearb;
        cand  = r;
        rearb = 0;
        m_to  = 0;
        if (m_own < 0) rearb = 1;
        else if (!r[m_own]) rearb = 1;
        else if (TO_EN && m_hold == MH-1 && (r & ~(8'(1) << m_own)) != 0) begin
            rearb = 1;
            m_to  = 1;
            cand[m_own] = 1'b0;
        end
        if (rearb) begin
            m_own  = -1;
            m_hold = 0;
            for (int k = 0; k < 8; k++)
                if (m_own < 0 && cand[(m_ptr + k) % 8]) m_own = (m_ptr + k) % 8;
            if (m_own >= 0) m_ptr = (m_own + 1) % 8;
        end else if (m_hold < MH-1) begin
            m_hold++;
        end
    endtask

    task automatic chk_model(input string nm);
        logic [7:0] eg;
        eg = (m_own < 0) ? 8'h00 : (8'(1) << m_own);
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".valid"}, 32'(gnt_valid), 32'(m_own >= 0));
        chk({nm, ".timeout"}, 32'(timeout), 32'(m_to));
        if (m_own >= 0) chk({nm, ".gnt_id"}, 32'(gnt_id), 32'(m_own));
    endtask

    task automatic step(input logic [7:0] r, input string nm);
        req = r;
        @(posedge clk);
        #1;
        model_edge(r);
        chk_model(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 8'h00;
        rst = 1'b1;
        #1;
        model_reset();
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.gnt_id", 32'(gnt_id), 32'h0);
        chk("reset.valid", 32'(gnt_valid), 32'h0);
        chk("reset.timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;

        vecs[0]  = '{8'h01, 8'h01};
        vecs[1]  = '{8'h00, 8'h00};
        vecs[2]  = '{8'h20, 8'h20};
        vecs[3]  = '{8'h21, 8'h20};  // owner 5 holds, 0 ignored
        vecs[4]  = '{8'h01, 8'h01};  // release hands over to 0 on same edge
        vecs[5]  = '{8'h00, 8'h00};
        vecs[6]  = '{8'h20, 8'h20};  // ptr becomes 6
        vecs[7]  = '{8'h00, 8'h00};
        vecs[8]  = '{8'h09, 8'h01};  // scan 6,7,0 -> 0
        vecs[9]  = '{8'h08, 8'h08};  // then 3
        vecs[10] = '{8'h00, 8'h00};
        vecs[11] = '{8'hFF, 8'h10};  // ptr 4

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].req, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.table", i), 32'(gnt), 32'(vecs[i].exp_gnt));
        end

        // full rotation, each owner holds 3 cycles then releases for one
        do_reset();
        step(8'hFF, "rot.first");
        chk("rot.first.table", 32'(gnt), 32'h01);
        for (int g = 0; g < 9; g++) begin
            step(8'hFF, "rot.hold");
            step(8'hFF, "rot.hold");
            chk($sformatf("rot%0d.owner", g), 32'(gnt), 32'(8'(1) << (g % 8)));
            r = 8'hFF & ~(8'(1) << (g % 8));
            step(r, "rot.release");
            chk($sformatf("rot%0d.next", g), 32'(gnt), 32'(8'(1) << ((g + 1) % 8)));
            chk($sformatf("rot%0d.novalidgap", g), 32'(gnt_valid), 32'h1);
        end

        // single requester release / re-assert: one idle cycle
        do_reset();
        step(8'h04, "single.grant");
        step(8'h00, "single.drop");
        chk("single.idle", 32'(gnt), 32'h0);
        step(8'h04, "single.regrant");
        chk("single.regrant.table", 32'(gnt), 32'h04);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                step(8'h03, "to.alt");
                chk($sformatf("to.c%0d.k%0d.gnt", c, k), 32'(gnt),
                    (c % 2 == 0) ? 32'h01 : 32'h02);
                chk($sformatf("to.c%0d.k%0d.pulse", c, k), 32'(timeout),
                    32'((k == 0) && (c > 0)));
            end
        end
        for (int k = 0; k < 20; k++) begin
            step(8'h01, "to.solo");
            chk("to.solo.pulse", 32'(timeout), 32'h0);
        end
        chk("to.solo.gnt", 32'(gnt), 32'h01);
`endif

        // asynchronous reset mid-grant
        do_reset();
        step(8'h10, "mid.grant");
        step(8'h10, "mid.hold");
        chk("mid.owner4", 32'(gnt), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid.async.gnt", 32'(gnt), 32'h0);
        chk("mid.async.valid", 32'(gnt_valid), 32'h0);
        chk("mid.async.id", 32'(gnt_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(8'h90, "mid.rearb");
        chk("mid.rearb.table", 32'(gnt), 32'h10);

        // random traffic against the model; bits toggle occasionally
        do_reset();
        r = 8'h00;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            step(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It selects a winner index each arbitration round and expands it into a one-hot grant vector through a 3-to-8 decoder. It holds the grant until the owner releases its request, or, when configured, until a hold limit expires. It sits between the requester ports and the shared datapath, and its one-hot grant drives per-requester select/enable lines directly.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles per owner when the timeout is compiled in; legal range 2..256.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i] high = requester i wants the resource; held high for the whole transaction.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_id  output  3  binary index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on the edge where a grant is revoked by the hold limit (ARB_TIMEOUT_EN only; otherwise tied 0).

## Operation
- Reset values: gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, priority pointer ptr=3'd0, hold counter=0, state IDLE.
- States:
  - IDLE → GRANT when req≠0.
  - GRANT → GRANT on handover to another requester.
  - GRANT → IDLE when the owner releases and req is otherwise 0.
- Winner search: the first set bit of req scanning ptr, ptr+1, …, ptr+7 (mod 8). The scan wraps 7→0.
- On any new grant to index w: ptr ← w+1 mod 8, gnt ← decode(w), gnt_id ← w, hold counter ← 0.
- While in GRANT with req[gnt_id]=1: grant is held unchanged, and the other requests are ignored.
- Owner release: req[gnt_id]=0 at an edge. At that same edge, a new winner is chosen from the remaining req bits, so handover occurs without an idle cycle. If no bits remain, go to IDLE.
- A requester dropping req while not granted has no effect. Request bits are not latched.
- gnt is always one-hot or zero and never changes except at a clock edge.
- gnt_valid = |gnt.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. A req rising before edge N produces gnt at edge N.
- Release-to-next-grant: 0 idle cycles. At the edge where the owner's req is sampled low, gnt switches directly to the next winner.
- A single requester that releases and re-asserts on the next cycle sees 1 cycle of gnt=0 and is then re-granted.
- Simultaneous requests from IDLE: lowest rotated index from ptr wins. After reset (ptr=0), req=8'hFF grants index 0.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronously). The first edge after deassertion re-arbitrates from ptr=0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter, of width $clog2(MAX_HOLD), increments every GRANT cycle.
  - When it reaches MAX_HOLD-1 and any other req bit is set, the next edge revokes the grant and grants the next rotated winner.
  - timeout pulses for 1 cycle on that edge.
  - The revoked owner must wait its round-robin turn.
  - If no other request is pending, the counter holds at MAX_HOLD-1 and the grant continues.
- ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - The grant is held until the owner releases.
  - timeout is tied to 0.

## Structure
- Shared package arb_pkg holds:
  - NUM_REQ=8 and IDX_W=3.
  - The state enum {ARB_IDLE, ARB_GRANT}.
  - A rotate-priority-find function returning {found, index}.
- One sub-module: onehot_dec3, a purely combinational 3-to-8 decoder (index → one-hot). It is instantiated once to form the next gnt value, which the top registers.

## Test plan
- Reset, then req=8'h01: gnt=8'h01, gnt_id=0, gnt_valid=1 one edge later. Drop req: gnt=0 next edge.
- req=8'hFF held, each owner releasing after 3 cycles and re-asserting 1 cycle later: grant order 0,1,2,…,7,0, with no idle cycles between owners.
- Owner 5 holds while req=8'h21 → drop req[5]: the same edge grants 0, and ptr becomes 1.
- Contention with wrap: ptr=6 (last grant 5), req=8'h09: grant goes to 0, then 3 after 0 releases.
- ARB_TIMEOUT_EN, MAX_HOLD=4:
  - req=8'h03 held continuously: grant 0 for 4 cycles, timeout pulse, grant 1 for 4 cycles, repeating.
  - With only req=8'h01: grant 0 indefinitely, timeout never asserts.
- Assert rst mid-grant (owner 4): gnt=0 immediately. After release with req=8'h90, grant 4 (ptr=0 scan order).
